dff_bank_scheduler: RTL
=======================

// Module: dff_bank_scheduler
// PURPOSE
//  Round-robin scheduler that shares one WIDTH-bit registered storage element
//  (a DFF bank) between NREQ requesters.
//  - Picks one pending writer, loads its data into the bank, and holds the
//    value stable for HOLD_CYCLES cycles.
//  - Reports the current owner while the value is held.
//  - Sits between the requesting blocks and the consumer of q.
// PARAMETERS
//  NREQ         4  number of requesters, >=2
//  WIDTH        8  data width of the shared bank, >=1
//  HOLD_CYCLES  3  cycles q_valid stays high per grant, >=1
// PORTS
//  clk      in   1            rising-edge clock
//  reset    in   1            synchronous, active-high reset
//  req      in   NREQ         req[i]=1: requester i has data pending; held until gnt[i]
//  wdata    in   NREQ*WIDTH   requester i data at [i*WIDTH +: WIDTH]; stable while req[i]
//  gnt      out  NREQ         one-hot, 1-cycle pulse: requester i's data captured this edge
//  q        out  WIDTH        bank contents
//  q_valid  out  1            high while the granted value is in its hold window
//  q_owner  out  $clog2(NREQ) index of the requester whose data is in q
//  busy     out  1            = q_valid; no new grant possible while busy and cnt!=0
// BEHAVIOUR
//  Reset:
//  - Takes effect at the clock edge where reset=1; reset wins over every other event.
//  - state=IDLE, q=0, q_valid=0, q_owner=0, gnt=0, busy=0, ptr=0, cnt=0.
//  - Reset mid-HOLD aborts the hold.
//  - A grant pulse due on that edge is suppressed; requesters keep req asserted.
//  States: IDLE, HOLD.
//  Grant decision:
//  - Taken when (state==IDLE) or (state==HOLD && cnt==0), and |req.
//  - Winner w = first i with req[i]=1, scanning ptr, ptr+1, ... mod NREQ.
//  Next edge after a grant decision (latency 1 from sampled req):
//  - q<=wdata[w], q_owner<=w, gnt<=onehot(w), q_valid<=1.
//  - cnt<=HOLD_CYCLES-1, state<=HOLD, ptr<=(w+1) mod NREQ (wraps NREQ-1 -> 0).
//  gnt is registered:
//  - High exactly one cycle, coincident with the first cycle q shows the new data.
//  - Requester sees gnt[i] and drops or updates req[i] on the following edge.
//  - The scheduler does not re-sample req[i] during the gnt cycle unless
//    HOLD_CYCLES==1; in that case requesters must deassert req[i] in the gnt cycle.
//  HOLD state:
//  - cnt!=0: cnt<=cnt-1; req ignored (not lost); q, q_owner stable.
//  - cnt==0 and no req: state<=IDLE, q_valid<=0, q and q_owner retain their values.
//  - cnt==0 and |req: back-to-back grant; q_valid stays high with no gap.
//  Timing:
//  - q_valid is high exactly HOLD_CYCLES cycles per grant.
//  - Maximum throughput is one grant per HOLD_CYCLES cycles.
//  Fairness: ptr advances only on a grant, so any asserted req is served
//    within NREQ grants.
//  req deasserted without a gnt (withdraw): allowed in any state; no effect on
//    the current hold.
//  Widths: cnt is $clog2(HOLD_CYCLES+1) bits; ptr and q_owner are $clog2(NREQ)
//    bits. All arithmetic is unsigned; ptr wrap is explicit (no reliance on
//    power-of-2 NREQ).
// STRUCTURE
//  Package dff_sched_pkg:
//  - typedef enum logic {IDLE, HOLD} sched_state_t.
//  - localparam helper OWNER_W(n) = (n>1) ? $clog2(n) : 1.
//  Sub-module rr_arbiter #(NREQ):
//  - Combinational; inputs req and ptr; outputs winner index and any_req.
//  - Reusable by other shared-resource controllers.
//  Top level: state register, cnt, ptr, and the q/q_owner/gnt/q_valid
//    registers, all in one always_ff on clk.
//  Interface: dff_sched_if(clk) carrying every port, reused by the class-based
//    bench environment.
// TESTING  (NREQ=4, WIDTH=8, HOLD_CYCLES=3 unless noted)
//  1. reset=1 for 2 cycles with req=4'hF
//     -> q=0, q_valid=0, gnt=0, busy=0, q_owner=0 throughout.
//  2. IDLE, req=4'b0100, wdata[2]=8'hA5 for 1 cycle
//     -> next cycle gnt=4'b0100, q=8'hA5, q_owner=2.
//     -> q_valid high exactly 3 cycles, then IDLE with q still 8'hA5.
//  3. req=4'hF held, wdata[i]=8'h10+i, each req dropped after its gnt
//     -> grants 0,1,2,3 at cycles t, t+3, t+6, t+9.
//     -> q = 10, 11, 12, 13 (hex); q_valid continuous for 12 cycles.
//  4. After a grant to requester 1 (ptr=2), assert req=4'b1001
//     -> requester 3 granted first; requester 0 granted 3 cycles later.
//  5. Grant to requester 2, assert reset in 2nd hold cycle while req[1]=1
//     -> next cycle all outputs at reset values.
//     -> first cycle after reset drops: decision taken; gnt=4'b0010 one cycle later.
//  6. HOLD_CYCLES=1 build, req[1] and req[2] asserted, each deasserted in its
//     gnt cycle and reasserted the next cycle
//     -> gnt alternates 0010/0100 every cycle; q_valid stays 1.
//  Scoreboard: a reference model predicts q/q_owner per gnt; it checks the
//    one-hot gnt, the q_valid window length, and ptr fairness.

Source files
------------

// File: rtl/dff_bank_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dff_sched_pkg
//  Purpose  : Shared types and helpers for the DFF bank scheduler and its
//             round-robin arbiter.
//  Contents : sched_state_t  - scheduler state encoding (IDLE, HOLD)
//             OWNER_W(n)     - width of an index into n requesters (min 1)
//  Revision : 1.0  initial release
// ============================================================================
package dff_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } sched_state_t;

  // A single requester still needs a 1-bit index signal.
  function automatic int OWNER_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dff_bank_scheduler_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin pick. Scans req starting at ptr and
//             wrapping modulo NREQ; reports the first asserted index.
//  Ports    : req     in   NREQ        pending requests
//             ptr     in   OWNER_W     index with highest priority
//             winner  out  OWNER_W     selected index (0 when none)
//             any_req out  1           at least one request pending
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
  import dff_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]            req,
  input  logic [OWNER_W(NREQ)-1:0]   ptr,
  output logic [OWNER_W(NREQ)-1:0]   winner,
  output logic                       any_req
);

  localparam int OW = OWNER_W(NREQ);

  logic w_found;
  int   w_idx;

  // Wrap is done with an explicit modulo so non-power-of-2 NREQ works.
  always_comb begin
    winner  = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = (int'(ptr) + k) % NREQ;
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        winner  = OW'(w_idx);
      end
    end
    any_req = |req;
  end

endmodule
`default_nettype wire

// File: rtl/dff_bank_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : dff_bank_scheduler
//  Purpose  : Shares one WIDTH-bit register bank between NREQ requesters.
//             A round-robin winner's data is captured and held valid for
//             HOLD_CYCLES cycles; the owner index is reported alongside.
//  Ports    : clk      in   1            rising-edge clock
//             reset    in   1            synchronous active-high reset
//             req      in   NREQ         pending write requests
//             wdata    in   NREQ*WIDTH   requester i data at [i*WIDTH +: WIDTH]
//             gnt      out  NREQ         one-hot, one-cycle capture pulse
//             q        out  WIDTH        bank contents
//             q_valid  out  1            high during the hold window
//             q_owner  out  OWNER_W      requester whose data is in q
//             busy     out  1            mirrors q_valid
//  Revision : 1.0  initial release
// ============================================================================
module dff_bank_scheduler
  import dff_sched_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     wdata,
  output logic [NREQ-1:0]           gnt,
  output logic [WIDTH-1:0]          q,
  output logic                      q_valid,
  output logic [OWNER_W(NREQ)-1:0]  q_owner,
  output logic                      busy
);

  localparam int OW = OWNER_W(NREQ);
  localparam int CW = $clog2(HOLD_CYCLES + 1);

  sched_state_t    r_state;
  logic [CW-1:0]   r_cnt;
  logic [OW-1:0]   r_ptr;
  logic [OW-1:0]   r_owner;
  logic [WIDTH-1:0] r_q;
  logic [NREQ-1:0] r_gnt;
  logic            r_q_valid;

  logic [OW-1:0]    w_winner;
  logic             w_any;
  logic             w_decide;
  logic [WIDTH-1:0] w_sel;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req),
    .ptr     (r_ptr),
    .winner  (w_winner),
    .any_req (w_any)
  );

  // Grant opportunity: idle, or the last cycle of a hold (back-to-back).
  assign w_decide = w_any && ((r_state == IDLE) || (r_cnt == '0));

  // Winner data mux.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_winner == OW'(i)) w_sel = wdata[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_q       <= '0;
      r_gnt     <= '0;
      r_q_valid <= 1'b0;
    end else begin
      r_gnt <= '0;
      if (w_decide) begin
        r_q       <= w_sel;
        r_owner   <= w_winner;
        r_gnt     <= NREQ'(1) << w_winner;
        r_q_valid <= 1'b1;
        r_cnt     <= CW'(HOLD_CYCLES - 1);
        r_state   <= HOLD;
        r_ptr     <= (w_winner == OW'(NREQ - 1)) ? '0 : w_winner + OW'(1);
      end else if (r_state == HOLD) begin
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - CW'(1);
        end else begin
          // Hold expired with nobody waiting: q/q_owner keep their values.
          r_state   <= IDLE;
          r_q_valid <= 1'b0;
        end
      end
    end
  end

  assign gnt     = r_gnt;
  assign q       = r_q;
  assign q_valid = r_q_valid;
  assign q_owner = r_owner;
  assign busy    = r_q_valid;

endmodule
`default_nettype wire
